// File: rtl/tcam_rep_policy_pkg.sv
// Shared constants and width helpers for the TCAM tag store and its victim selector.
// Build option TCAM_FLUSH_EN (see tcam_rep_policy.sv) does not change this package.
package tcam_rep_policy_pkg;

  localparam int POLICY_FIFO = 0;
  localparam int POLICY_LFSR = 1;

  // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback taps are bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int tagWidth(input int addrWidth, input int offsetWidth);
    return addrWidth - offsetWidth;
  endfunction

  function automatic int indexWidth(input int setNum);
    return (setNum > 1) ? $clog2(setNum) : 1;
  endfunction

  function automatic logic [15:0] lfsrNext(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

endpackage

// File: rtl/tcam_rep_policy_if.sv
// Request/lookup bus between the cache controller (master) and the TCAM tag store (slave).
// With TCAM_FLUSH_EN defined the bus also carries the flush strobe.
interface tcam_rep_policy_if
  import tcam_rep_policy_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int SET_NUM      = 256,
  parameter int OFFSET_WIDTH = 2
);
  localparam int TAG_WIDTH   = tagWidth(ADDR_WIDTH, OFFSET_WIDTH);
  localparam int INDEX_WIDTH = indexWidth(SET_NUM);

  logic                   valid;
  logic [ADDR_WIDTH-1:0]  addr;
`ifdef TCAM_FLUSH_EN
  logic                   flush;
`endif
  logic                   h;
  logic [INDEX_WIDTH-1:0] hitIndex;
  logic [INDEX_WIDTH-1:0] repPtr;
  logic [TAG_WIDTH-1:0]   replacedTag;
  logic                   replacedVld;

  modport master (
`ifdef TCAM_FLUSH_EN
    output flush,
`endif
    output valid, addr,
    input  h, hitIndex, repPtr, replacedTag, replacedVld
  );

  modport slave (
`ifdef TCAM_FLUSH_EN
    input  flush,
`endif
    input  valid, addr,
    output h, hitIndex, repPtr, replacedTag, replacedVld
  );

endinterface

// File: rtl/tcam_rep_policy_victim_select.sv
// Victim selection: lowest invalid entry if one exists, otherwise the FIFO counter or LFSR pointer.
// The policy state only moves when a full table allocates (i_advance).
module tcam_rep_policy_victim_select
  import tcam_rep_policy_pkg::*;
#(
  parameter int SET_NUM = 256,
  parameter int POLICY  = POLICY_FIFO,
  localparam int INDEX_WIDTH = indexWidth(SET_NUM)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [SET_NUM-1:0]     i_vld,
  input  logic                   i_advance,
  output logic [INDEX_WIDTH-1:0] o_repPtr
);

  logic [INDEX_WIDTH-1:0] w_policyPtr;
  logic [INDEX_WIDTH-1:0] w_freeIdx;
  logic                   w_anyFree;

  if (POLICY == POLICY_LFSR) begin : g_lfsr
    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_lfsr <= LFSR_SEED;
      end else if (i_advance) begin
        r_lfsr <= lfsrNext(r_lfsr);
      end
    end

    assign w_policyPtr = r_lfsr[INDEX_WIDTH-1:0];
  end else begin : g_fifo
    logic [INDEX_WIDTH-1:0] r_fifoPtr;

    // SET_NUM is a power of two, so natural overflow gives the wrap to 0.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_fifoPtr <= '0;
      end else if (i_advance) begin
        r_fifoPtr <= r_fifoPtr + INDEX_WIDTH'(1);
      end
    end

    assign w_policyPtr = r_fifoPtr;
  end

  // Scanning downward leaves the lowest invalid index as the final assignment.
  always_comb begin
    w_freeIdx = '0;
    w_anyFree = ~&i_vld;
    for (int i = SET_NUM - 1; i >= 0; i--) begin
      if (!i_vld[i]) begin
        w_freeIdx = INDEX_WIDTH'(i);
      end
    end
  end

  assign o_repPtr = w_anyFree ? w_freeIdx : w_policyPtr;

endmodule

// File: rtl/tcam_rep_policy.sv
// Fully associative tag store with single-cycle lookup and built-in victim selection.
// Define TCAM_FLUSH_EN to add a bus flush strobe that clears every valid bit.
module tcam_rep_policy
  import tcam_rep_policy_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int SET_NUM      = 256,
  parameter int OFFSET_WIDTH = 2,
  parameter int POLICY       = POLICY_FIFO
) (
  input logic              i_clk,
  input logic              i_reset,
  tcam_rep_policy_if.slave bus
);

  localparam int TAG_WIDTH   = tagWidth(ADDR_WIDTH, OFFSET_WIDTH);
  localparam int INDEX_WIDTH = indexWidth(SET_NUM);

  logic [TAG_WIDTH-1:0]   r_tag [SET_NUM];
  logic [SET_NUM-1:0]     r_vld;

  logic [TAG_WIDTH-1:0]   w_reqTag;
  logic [SET_NUM-1:0]     w_match;
  logic [INDEX_WIDTH-1:0] w_matchIdx;
  logic                   w_hit;
  logic                   w_alloc;
  logic                   w_flush;
  logic                   w_advance;
  logic [INDEX_WIDTH-1:0] w_repPtr;
  logic                   w_unusedOffset;

  assign w_reqTag       = bus.addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign w_unusedOffset = ^bus.addr[OFFSET_WIDTH-1:0];

`ifdef TCAM_FLUSH_EN
  assign w_flush = bus.flush;
`else
  assign w_flush = 1'b0;
`endif

  always_comb begin
    w_match = '0;
    for (int i = 0; i < SET_NUM; i++) begin
      w_match[i] = r_vld[i] && (r_tag[i] == w_reqTag);
    end
  end

  // Allocation only happens on a miss, so at most one entry matches; downward scan still picks the lowest.
  always_comb begin
    w_matchIdx = '0;
    for (int i = SET_NUM - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_matchIdx = INDEX_WIDTH'(i);
      end
    end
  end

  assign w_hit        = bus.valid && (|w_match);
  assign bus.h        = w_hit;
  assign bus.hitIndex = w_hit ? w_matchIdx : '0;

  assign w_alloc   = bus.valid && !w_hit && !w_flush;
  assign w_advance = w_alloc && (&r_vld);

  tcam_rep_policy_victim_select #(
    .SET_NUM (SET_NUM),
    .POLICY  (POLICY)
  ) u_victimSelect (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_vld     (r_vld),
    .i_advance (w_advance),
    .o_repPtr  (w_repPtr)
  );

  assign bus.repPtr      = w_repPtr;
  assign bus.replacedTag = r_tag[w_repPtr];
  assign bus.replacedVld = r_vld[w_repPtr];

  // Flush clears only valid bits; tags stay so replacedTag still reports the stale contents.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= '0;
      for (int i = 0; i < SET_NUM; i++) begin
        r_tag[i] <= '0;
      end
    end else if (w_flush) begin
      r_vld <= '0;
    end else if (w_alloc) begin
      r_tag[w_repPtr] <= w_reqTag;
      r_vld[w_repPtr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcam_rep_policy.sv
// Bench: a FIFO and an LFSR instance (SET_NUM=4) driven in lockstep against a behavioural scoreboard.
// Flush steps are included when TCAM_FLUSH_EN is defined.
module tb_tcam_rep_policy;

  localparam int AW = 32;
  localparam int SN = 4;
  localparam int OW = 2;
  localparam int TW = AW - OW;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  tcam_rep_policy_if #(.ADDR_WIDTH(AW), .SET_NUM(SN), .OFFSET_WIDTH(OW)) busFifo ();
  tcam_rep_policy_if #(.ADDR_WIDTH(AW), .SET_NUM(SN), .OFFSET_WIDTH(OW)) busLfsr ();

  tcam_rep_policy #(.ADDR_WIDTH(AW), .SET_NUM(SN), .OFFSET_WIDTH(OW), .POLICY(0)) dutFifo (
    .i_clk   (clock),
    .i_reset (reset),
    .bus     (busFifo)
  );

  tcam_rep_policy #(.ADDR_WIDTH(AW), .SET_NUM(SN), .OFFSET_WIDTH(OW), .POLICY(1)) dutLfsr (
    .i_clk   (clock),
    .i_reset (reset),
    .bus     (busLfsr)
  );

  typedef struct {
    string         name;
    int            dut;
    logic          h;
    logic [IW-1:0] hitIndex;
    logic [IW-1:0] repPtr;
    logic [TW-1:0] replTag;
    logic          replVld;
  } expect_t;

  expect_t sbQueue [$];

  logic [TW-1:0] mTag [2][SN];
  logic          mVld [2][SN];
  logic [IW-1:0] mFifo;
  logic [15:0]   mLfsr;

  int checks = 0;
  int errors = 0;

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form, seed ACE1.
  function automatic logic [15:0] modelLfsrStep(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic void modelLookup(input int d, input logic valid, input logic [AW-1:0] addr,
                                      output logic h, output logic [IW-1:0] hi,
                                      output logic [IW-1:0] rep);
    logic [TW-1:0] t;
    logic found;
    t = addr[AW-1:OW];
    h = 1'b0;
    hi = '0;
    for (int i = 0; i < SN; i++) begin
      if (!h && mVld[d][i] && (mTag[d][i] == t)) begin
        h = 1'b1;
        hi = IW'(i);
      end
    end
    if (!valid) begin
      h = 1'b0;
      hi = '0;
    end
    found = 1'b0;
    rep = '0;
    for (int i = 0; i < SN; i++) begin
      if (!found && !mVld[d][i]) begin
        found = 1'b1;
        rep = IW'(i);
      end
    end
    if (!found) rep = (d == 0) ? mFifo : mLfsr[IW-1:0];
  endfunction

  task automatic predict(input string name, input logic valid, input logic [AW-1:0] addr);
    expect_t e;
    for (int d = 0; d < 2; d++) begin
      e.name = name;
      e.dut  = d;
      modelLookup(d, valid, addr, e.h, e.hitIndex, e.repPtr);
      e.replTag = mTag[d][e.repPtr];
      e.replVld = mVld[d][e.repPtr];
      sbQueue.push_back(e);
    end
  endtask

  task automatic modelClock(input logic valid, input logic [AW-1:0] addr, input logic rst,
                            input logic flush);
    logic h;
    logic [IW-1:0] hi;
    logic [IW-1:0] rep;
    logic full;
    logic doFlush;
    doFlush = 1'b0;
`ifdef TCAM_FLUSH_EN
    doFlush = flush;
`endif
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < SN; i++) begin
          mVld[d][i] = 1'b0;
          mTag[d][i] = '0;
        end
      mFifo = '0;
      mLfsr = 16'hACE1;
    end else if (doFlush) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < SN; i++) mVld[d][i] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        modelLookup(d, valid, addr, h, hi, rep);
        if (valid && !h) begin
          full = 1'b1;
          for (int i = 0; i < SN; i++) if (!mVld[d][i]) full = 1'b0;
          mTag[d][rep] = addr[AW-1:OW];
          mVld[d][rep] = 1'b1;
          if (full && d == 0) mFifo = mFifo + 1'b1;
          if (full && d == 1) mLfsr = modelLfsrStep(mLfsr);
        end
      end
    end
  endtask

  task automatic compareField(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    expect_t e;
    string pfx;
    logic          oh;
    logic [IW-1:0] ohi;
    logic [IW-1:0] orep;
    logic [TW-1:0] otag;
    logic          ovld;
    for (int k = 0; k < 2; k++) begin
      e = sbQueue.pop_front();
      if (e.dut == 0) begin
        oh = busFifo.h; ohi = busFifo.hitIndex; orep = busFifo.repPtr;
        otag = busFifo.replacedTag; ovld = busFifo.replacedVld;
        pfx = {"fifo.", e.name};
      end else begin
        oh = busLfsr.h; ohi = busLfsr.hitIndex; orep = busLfsr.repPtr;
        otag = busLfsr.replacedTag; ovld = busLfsr.replacedVld;
        pfx = {"lfsr.", e.name};
      end
      compareField({pfx, ".h"},           32'(oh),   32'(e.h));
      compareField({pfx, ".hitIndex"},    32'(ohi),  32'(e.hitIndex));
      compareField({pfx, ".repPtr"},      32'(orep), 32'(e.repPtr));
      compareField({pfx, ".replacedTag"}, 32'(otag), 32'(e.replTag));
      compareField({pfx, ".replacedVld"}, 32'(ovld), 32'(e.replVld));
    end
  endtask

  // One clock of stimulus: drive, predict, check mid-cycle, then advance the model with the DUT edge.
  task automatic applyStimulus(input string name, input logic valid, input logic [AW-1:0] addr,
                               input logic rst, input logic flush);
    reset = rst;
    busFifo.valid = valid;
    busFifo.addr  = addr;
    busLfsr.valid = valid;
    busLfsr.addr  = addr;
`ifdef TCAM_FLUSH_EN
    busFifo.flush = flush;
    busLfsr.flush = flush;
`endif
    predict(name, valid, addr);
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    modelClock(valid, addr, rst, flush);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    busFifo.valid = 1'b0; busFifo.addr = '0;
    busLfsr.valid = 1'b0; busLfsr.addr = '0;
`ifdef TCAM_FLUSH_EN
    busFifo.flush = 1'b0;
    busLfsr.flush = 1'b0;
`endif
    @(posedge clock);
    modelClock(1'b0, '0, 1'b1, 1'b0);
    #1;

    applyStimulus("afterReset",  1'b0, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus("miss10",      1'b1, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus("hit10",       1'b1, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus("miss20",      1'b1, 32'h0000_0020, 1'b0, 1'b0);
    applyStimulus("miss30",      1'b1, 32'h0000_0030, 1'b0, 1'b0);
    applyStimulus("idleRep3",    1'b0, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus("hit22",       1'b1, 32'h0000_0022, 1'b0, 1'b0);
    applyStimulus("noValid30",   1'b0, 32'h0000_0030, 1'b0, 1'b0);
    applyStimulus("hit30",       1'b1, 32'h0000_0030, 1'b0, 1'b0);
    applyStimulus("resetMiss40", 1'b1, 32'h0000_0040, 1'b1, 1'b0);
    applyStimulus("afterRst40",  1'b1, 32'h0000_0010, 1'b0, 1'b0);

    applyStimulus("rst2",        1'b0, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus("fillA",       1'b1, 32'h0000_0100, 1'b0, 1'b0);
    applyStimulus("fillB",       1'b1, 32'h0000_0200, 1'b0, 1'b0);
    applyStimulus("fillC",       1'b1, 32'h0000_0300, 1'b0, 1'b0);
    applyStimulus("fillD",       1'b1, 32'h0000_0400, 1'b0, 1'b0);
    applyStimulus("fullIdle",    1'b0, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus("missE",       1'b1, 32'h0000_0500, 1'b0, 1'b0);
    applyStimulus("hitD",        1'b1, 32'h0000_0400, 1'b0, 1'b0);
    applyStimulus("hitDagain",   1'b1, 32'h0000_0403, 1'b0, 1'b0);
    applyStimulus("missF",       1'b1, 32'h0000_0600, 1'b0, 1'b0);
    applyStimulus("missG",       1'b1, 32'h0000_0700, 1'b0, 1'b0);
    applyStimulus("missH",       1'b1, 32'h0000_0800, 1'b0, 1'b0);
    applyStimulus("missIwrap",   1'b1, 32'h0000_0900, 1'b0, 1'b0);
    applyStimulus("missJ",       1'b1, 32'h0000_0A00, 1'b0, 1'b0);
    applyStimulus("hitJ",        1'b1, 32'h0000_0A00, 1'b0, 1'b0);
    applyStimulus("finalIdle",   1'b0, 32'h0000_0000, 1'b0, 1'b0);

`ifdef TCAM_FLUSH_EN
    applyStimulus("rst3",        1'b0, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus("flFill10",    1'b1, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus("flFill20",    1'b1, 32'h0000_0020, 1'b0, 1'b0);
    applyStimulus("flHit10",     1'b1, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus("flushMiss30", 1'b1, 32'h0000_0030, 1'b0, 1'b1);
    applyStimulus("postFlush",   1'b0, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus("flMiss10",    1'b1, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus("flRehit10",   1'b1, 32'h0000_0010, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
